// File: rtl/dma_int_pkg.sv
// Shared definitions for the DMA interrupt status queue: register indices,
// status-entry field positions and the per-channel presentation FSM states.
package dma_int_pkg;

  localparam int ENT_W        = 44;
  localparam int ENT_BITS_LSB = 0;
  localparam int ENT_NUM_LSB  = 4;
  localparam int ENT_ADDR_LSB = 10;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_CLEAR  = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd3;
  localparam logic [2:0] REG_ACC    = 3'd4;
  localparam logic [2:0] REG_DROP   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } ch_state_t;

endpackage

// File: rtl/dma_int_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after pop) and
// an occupancy count; a push into a full FIFO is taken only alongside a pop.
module dma_int_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) begin
        rdata <= mem[rp];
        rp    <= rp + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_int_queue_ctrl.sv
// Multi-channel DMA interrupt status queue: per-channel FIFO, head entry shown in a status register.
// Event counters per channel are built only when INT_QUEUE_STATS_EN is defined.
module dma_int_queue_ctrl
  import dma_int_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int WMARK       = 3,
  parameter int CH_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrlSel,
  input  logic              ctrlWr,
  input  logic [CH_W+2:0]   ctrlAddr,
  input  logic [31:0]       ctrlWrData,
  input  logic              ctrlWrStrbs,
  output logic [31:0]       ctrlRdData,
  input  logic              valid,
  input  logic [CH_W-1:0]   chNum,
  input  logic              opDone,
  input  logic              wrError,
  input  logic              rdError,
  input  logic              inValidDscrptr,
  input  logic [5:0]        dscrptrNum,
  input  logic [31:0]       dscrptrAddr,
  output logic [NUM_CH-1:0] fifoFullQueue,
  output logic [NUM_CH-1:0] intX,
  output logic              intAny
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic              wr_en;
  logic [CH_W-1:0]   addr_ch;
  logic [2:0]        addr_reg;
  logic [ENT_W-1:0]  ev_ent;
  logic [31:0]       ch_rd [NUM_CH];
  logic [NUM_CH-1:0] int_nxt;
  logic [26:0]       unused_wdata;

  assign wr_en               = ctrlSel & ctrlWr & ctrlWrStrbs;
  assign {addr_ch, addr_reg} = ctrlAddr;
  assign ev_ent              = {dscrptrAddr, dscrptrNum, inValidDscrptr, rdError, wrError, opDone};
  assign unused_wdata        = ctrlWrData[31:5];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             ch_sel, hit, pop, accept, drop, mask_we;
    logic             empty, full;
    logic [ENT_W-1:0] rd_ent;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       cnt6;
    logic [4:0]       occ, clr, mask;
    ch_state_t        state;
    logic [3:0]       bits;
    logic [5:0]       num;
    logic [31:0]      addr;
    logic             ovf, int_r, ffq_r;
    logic [31:0]      rd_val;

    assign ch_sel  = (addr_ch == CH_W'(g));
    assign clr     = (wr_en && ch_sel && addr_reg == REG_CLEAR) ? ctrlWrData[4:0] : 5'd0;
    assign mask_we = wr_en && ch_sel && addr_reg == REG_MASK;
    assign hit     = valid && (chNum == CH_W'(g));
    assign pop     = (state == ST_IDLE) && !empty;
    assign accept  = hit && (!full || pop);
    assign drop    = hit && full && !pop;

    dma_int_fifo #(.W(ENT_W), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .wdata (ev_ent),
      .pop   (pop),
      .rdata (rd_ent),
      .count (cnt),
      .empty (empty),
      .full  (full)
    );

    assign int_nxt[g] = (|(bits & mask[3:0])) | (ovf & mask[4]);

    // A clear arriving during FETCH is dropped so the freshly loaded entry survives.
    always_ff @(posedge clock) begin
      if (reset) begin
        state <= ST_IDLE;
        bits  <= '0;
        num   <= '0;
        addr  <= '0;
        ovf   <= 1'b0;
        mask  <= '0;
        int_r <= 1'b0;
        ffq_r <= 1'b0;
      end else begin
        ovf   <= drop | (ovf & ~clr[4]);
        int_r <= int_nxt[g];
        ffq_r <= (cnt >= CNT_W'(WMARK));
        if (mask_we) mask <= ctrlWrData[4:0];
        case (state)
          ST_IDLE: begin
            if (!empty) state <= ST_FETCH;
          end
          ST_FETCH: begin
            bits  <= rd_ent[ENT_BITS_LSB +: 4];
            num   <= rd_ent[ENT_NUM_LSB +: 6];
            addr  <= rd_ent[ENT_ADDR_LSB +: 32];
            state <= ST_HOLD;
          end
          ST_HOLD: begin
            bits <= bits & ~clr[3:0];
            if ((bits & ~clr[3:0]) == 4'd0) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign intX[g]          = int_r;
    assign fifoFullQueue[g] = ffq_r;

    // The status occupancy field is 5 bits wide; a full 32-deep queue reads as 31.
    assign cnt6 = 6'(cnt);
    assign occ  = cnt6[5] ? 5'h1F : cnt6[4:0];

`ifdef INT_QUEUE_STATS_EN
    logic [15:0] acc_cnt, drp_cnt;
    logic        st_clr;

    assign st_clr = wr_en && ch_sel && (addr_reg == REG_ACC || addr_reg == REG_DROP) && ctrlWrData[0];

    always_ff @(posedge clock) begin
      if (reset || st_clr) begin
        acc_cnt <= '0;
        drp_cnt <= '0;
      end else begin
        if (accept && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 1'b1;
        if (drop && drp_cnt != 16'hFFFF) drp_cnt <= drp_cnt + 1'b1;
      end
    end
`endif

    always_comb begin
      rd_val = '0;
      case (addr_reg)
        REG_STATUS: rd_val = {16'd0, occ, ovf, num, bits};
        REG_MASK:   rd_val = {27'd0, mask};
        REG_ADDR:   rd_val = addr;
`ifdef INT_QUEUE_STATS_EN
        REG_ACC:    rd_val = {16'd0, acc_cnt};
        REG_DROP:   rd_val = {16'd0, drp_cnt};
`endif
        default:    rd_val = '0;
      endcase
    end

    assign ch_rd[g] = rd_val;
  end

  always_comb begin
    ctrlRdData = '0;
    if (ctrlSel) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_ch == CH_W'(i)) ctrlRdData = ch_rd[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) intAny <= 1'b0;
    else       intAny <= |int_nxt;
  end

endmodule

// File: tb/tb_dma_int_queue_ctrl.sv
// Bench for dma_int_queue_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-level reference model.
module tb_dma_int_queue_ctrl;

  localparam int NCH = 4;
  localparam int QD  = 4;
  localparam int WM  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrlSel, ctrlWr, ctrlWrStrbs;
  logic [5:0]  ctrlAddr;
  logic [31:0] ctrlWrData, ctrlRdData;
  logic        valid;
  logic [2:0]  chNum;
  logic        opDone, wrError, rdError, inValidDscrptr;
  logic [5:0]  dscrptrNum;
  logic [31:0] dscrptrAddr;
  logic [3:0]  fifoFullQueue, intX;
  logic        intAny;

  int n_tests = 0;
  int n_fail  = 0;

  dma_int_queue_ctrl #(.NUM_CH(NCH), .QUEUE_DEPTH(QD), .WMARK(WM), .CH_W(3)) dut (
    .clock(clock), .reset(reset),
    .ctrlSel(ctrlSel), .ctrlWr(ctrlWr), .ctrlAddr(ctrlAddr), .ctrlWrData(ctrlWrData),
    .ctrlWrStrbs(ctrlWrStrbs), .ctrlRdData(ctrlRdData),
    .valid(valid), .chNum(chNum), .opDone(opDone), .wrError(wrError), .rdError(rdError),
    .inValidDscrptr(inValidDscrptr), .dscrptrNum(dscrptrNum), .dscrptrAddr(dscrptrAddr),
    .fifoFullQueue(fifoFullQueue), .intX(intX), .intAny(intAny)
  );

  always #5 clock = ~clock;

  // Reference model: a plain FIFO per channel, the entry being fetched, and the presented entry.
  logic [43:0] m_fifo [NCH][QD];
  int          m_head [NCH];
  int          m_cnt  [NCH];
  logic        m_infl [NCH];
  logic [43:0] m_infl_e [NCH];
  logic        m_held [NCH];
  logic [3:0]  m_bits [NCH];
  logic [5:0]  m_num  [NCH];
  logic [31:0] m_addr [NCH];
  logic        m_ovf  [NCH];
  logic [4:0]  m_mask [NCH];
  int          m_acc  [NCH];
  int          m_drp  [NCH];
  logic [3:0]  m_int, m_ffq;
  logic        m_any;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_head[c] = 0; m_cnt[c] = 0; m_infl[c] = 1'b0; m_infl_e[c] = '0; m_held[c] = 1'b0;
      m_bits[c] = '0; m_num[c] = '0; m_addr[c] = '0; m_ovf[c] = 1'b0; m_mask[c] = '0;
      m_acc[c] = 0; m_drp[c] = 0;
    end
    m_int = '0; m_ffq = '0; m_any = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int          c;
    int          occ;
    logic [31:0] d;
    c = int'(a[5:3]);
    d = '0;
    if (c < NCH) begin
      case (a[2:0])
        3'd0: begin
          occ = (m_cnt[c] > 31) ? 31 : m_cnt[c];
          d = {16'd0, 5'(occ), m_ovf[c], m_num[c], m_bits[c]};
        end
        3'd1: d = {27'd0, m_mask[c]};
        3'd3: d = m_addr[c];
`ifdef INT_QUEUE_STATS_EN
        3'd4: d = 32'(m_acc[c]);
        3'd5: d = 32'(m_drp[c]);
`endif
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  task automatic model_edge(input logic v, input logic [2:0] ch, input logic [43:0] e,
                            input logic we, input logic [5:0] a, input logic [31:0] wd);
    logic [3:0] ni, nf;
    for (int c = 0; c < NCH; c++) begin
      logic [4:0] clr;
      logic       sel, pop, hit, acc, drop;
      logic [3:0] nb;
      sel  = we && (int'(a[5:3]) == c);
      clr  = (sel && a[2:0] == 3'd2) ? wd[4:0] : 5'd0;
      ni[c] = (|(m_bits[c] & m_mask[c][3:0])) | (m_ovf[c] & m_mask[c][4]);
      nf[c] = (m_cnt[c] >= WM);
      pop  = !m_infl[c] && !m_held[c] && m_cnt[c] > 0;
      if (m_infl[c]) begin
        m_bits[c] = m_infl_e[c][3:0];
        m_num[c]  = m_infl_e[c][9:4];
        m_addr[c] = m_infl_e[c][43:10];
        m_held[c] = 1'b1;
      end else if (m_held[c]) begin
        nb = m_bits[c] & ~clr[3:0];
        m_bits[c] = nb;
        if (nb == 4'd0) m_held[c] = 1'b0;
      end
      m_infl[c] = pop;
      if (pop) begin
        m_infl_e[c] = m_fifo[c][m_head[c]];
        m_head[c] = (m_head[c] + 1) % QD;
        m_cnt[c]--;
      end
      hit  = v && (int'(ch) == c);
      acc  = hit && (m_cnt[c] < QD);
      drop = hit && !acc;
      if (acc) begin
        m_fifo[c][(m_head[c] + m_cnt[c]) % QD] = e;
        m_cnt[c]++;
      end
      m_ovf[c] = drop || (m_ovf[c] && !clr[4]);
      if (sel && a[2:0] == 3'd1) m_mask[c] = wd[4:0];
`ifdef INT_QUEUE_STATS_EN
      if (sel && (a[2:0] == 3'd4 || a[2:0] == 3'd5) && wd[0]) begin
        m_acc[c] = 0; m_drp[c] = 0;
      end else begin
        if (acc && m_acc[c] < 65535) m_acc[c]++;
        if (drop && m_drp[c] < 65535) m_drp[c]++;
      end
`endif
    end
    m_int = ni; m_ffq = nf; m_any = |ni;
  endtask

  task automatic step(input logic v, input logic [2:0] ch, input logic [43:0] e,
                      input logic sel, input logic wr, input logic strb,
                      input logic [5:0] a, input logic [31:0] wd);
    valid = v; chNum = ch;
    {dscrptrAddr, dscrptrNum, inValidDscrptr, rdError, wrError, opDone} = e;
    ctrlSel = sel; ctrlWr = wr; ctrlWrStrbs = strb; ctrlAddr = a; ctrlWrData = wd;
    #1;
    if (sel && !wr) check("rdata", ctrlRdData, model_read(a));
    @(posedge clock);
    model_edge(v, ch, e, sel && wr && strb, a, wd);
    #1;
    check("intX", 32'(intX), 32'(m_int));
    check("intAny", 32'(intAny), 32'(m_any));
    check("fifoFullQueue", 32'(fifoFullQueue), 32'(m_ffq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 44'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    step(1'b0, 3'd0, 44'd0, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic push(input logic [2:0] ch, input logic [3:0] b, input logic [5:0] n, input logic [31:0] ad);
    step(1'b1, ch, {ad, n, b}, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    valid = 1'b0; ctrlSel = 1'b1; ctrlWr = 1'b0; ctrlWrStrbs = 1'b0; ctrlAddr = a;
    #1;
    d = ctrlRdData;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b0; chNum = '0; ctrlSel = 1'b0; ctrlWr = 1'b0; ctrlWrStrbs = 1'b0;
    ctrlAddr = '0; ctrlWrData = '0;
    {dscrptrAddr, dscrptrNum, inValidDscrptr, rdError, wrError, opDone} = '0;
    @(posedge clock);
    #1;
    model_reset();
    check("rst_intX", 32'(intX), 32'd0);
    check("rst_intAny", 32'(intAny), 32'd0);
    check("rst_ffq", 32'(fifoFullQueue), 32'd0);
    reset = 1'b0;
  endtask

  task automatic rand_step(input int pv, input int pclr);
    logic        v, sel, w, strb;
    logic [2:0]  ch;
    logic [43:0] e;
    logic [5:0]  a;
    logic [31:0] wd;
    int          r;
    v  = ($urandom_range(99) < pv);
    ch = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(3));
    e  = {32'($urandom), 6'($urandom_range(33)), 4'($urandom_range(15))};
    r  = int'($urandom_range(99));
    sel = 1'b0; w = 1'b0; strb = 1'b0;
    a  = 6'($urandom_range(63));
    wd = $urandom;
    if (r < pclr) begin
      sel = 1'b1; w = 1'b1; strb = 1'b1; a = {3'($urandom_range(3)), 3'd2};
    end else if (r < pclr + 5) begin
      sel = 1'b1; w = 1'b1; strb = 1'b1; a = {3'($urandom_range(3)), 3'd1};
    end else if (r < pclr + 12) begin
      sel = 1'b1; w = 1'b1; strb = 1'($urandom_range(1));
    end else if (r < pclr + 50) begin
      sel = 1'b1;
    end
    step(v, ch, e, sel, w, strb, a, wd);
  endtask

  initial begin
    logic [31:0] d;
    do_reset();

    // ch2: single opDone event, interrupt three edges after valid
    wr({3'd2, 3'd1}, 32'h1);
    push(3'd2, 4'b0001, 6'd5, 32'hA000_0040);
    idle(1); check("t1_int_n1", 32'(intX[2]), 32'd0);
    idle(1); check("t1_int_n2", 32'(intX[2]), 32'd0);
    idle(1); check("t1_int_n3", 32'(intX[2]), 32'd1);
    rd({3'd2, 3'd0}, d); check("t1_status", d, 32'h0000_0051);
    wr({3'd2, 3'd2}, 32'h1); check("t1_clr_m", 32'(intX[2]), 32'd1);
    idle(1); check("t1_clr_m1", 32'(intX[2]), 32'd0);

    // ch0: three queued events presented in order
    wr({3'd0, 3'd1}, 32'hF);
    push(3'd0, 4'b0001, 6'd1, 32'h1000);
    push(3'd0, 4'b0010, 6'd2, 32'h2000);
    push(3'd0, 4'b0100, 6'd3, 32'h3000);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      rd({3'd0, 3'd0}, d);
      check("t2_bits", 32'(d[3:0]), 32'(1 << k));
      check("t2_occ", 32'(d[15:11]), 32'(2 - k));
      wr({3'd0, 3'd2}, 32'hF);
      idle(2);
    end

    // ch1: hold head, overfill the queue
    wr({3'd1, 3'd1}, 32'h1F);
    push(3'd1, 4'b0001, 6'd7, 32'h7000);
    idle(3);
    for (int k = 0; k < 5; k++) push(3'd1, 4'b0010, 6'(k), 32'(k));
    idle(2);
    rd({3'd1, 3'd0}, d);
    check("t3_ovf", 32'(d[10]), 32'd1);
    check("t3_occ", 32'(d[15:11]), 32'd4);
    check("t3_ffq", 32'(fifoFullQueue[1]), 32'd1);
    wr({3'd1, 3'd1}, 32'h10);
    idle(2); check("t3_int_ovf", 32'(intX[1]), 32'd1);
    wr({3'd1, 3'd2}, 32'h10);
    idle(2); check("t3_int_ovfclr", 32'(intX[1]), 32'd0);

    // ch3: clear coinciding with the status load is discarded
    wr({3'd3, 3'd1}, 32'h1);
    push(3'd3, 4'b0001, 6'd9, 32'h9000);
    idle(1);
    wr({3'd3, 3'd2}, 32'h1F);
    idle(1); check("t4_int", 32'(intX[3]), 32'd1);
    rd({3'd3, 3'd0}, d); check("t4_bits", 32'(d[3:0]), 32'd1);

    // out-of-range channel events and reads
    push(3'd4, 4'b1111, 6'd1, 32'h1);
    push(3'd7, 4'b1111, 6'd1, 32'h1);
    rd({3'd4, 3'd0}, d); check("t5_rd_ch4", d, 32'd0);
    rd({3'd7, 3'd1}, d); check("t5_rd_ch7", d, 32'd0);
    idle(1);
    rd({3'd0, 3'd0}, d); check("t5_ch0_flags", 32'(d[15:10]), 32'd0);
    idle(1);

    for (int i = 0; i < 800; i++) rand_step(60, 10);
    for (int i = 0; i < 600; i++) rand_step(20, 40);
    do_reset();
    for (int i = 0; i < 600; i++) rand_step(40, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
